decode_issue_ctrl: RTL and testbench

- Sequences the decode stage.
- Holds one fetched instruction in a skid register and checks its source and destination registers against a pending-write scoreboard.
- Issues the instruction downstream with a valid/ready handshake only when it is hazard-free.
- Sits between fetch and the decode datapath: drives ra1/ra2 indices, accepts writeback retirements and flushes, and exports a stall-cycle counter.

---
 rtl/decode_issue_ctrl_pkg.sv | 23 ++
 rtl/decode_issue_ctrl_if.sv | 30 +++
 rtl/decode_issue_ctrl_issue_scoreboard.sv | 51 +++++
 rtl/decode_issue_ctrl.sv | 84 ++++++++
 tb/tb_decode_issue_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue controller: register index and the
// per-instruction fields the controller holds and checks for hazards.
package decode_issue_ctrl_pkg;

   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] creg_addr_t;

   typedef struct packed {
      creg_addr_t rs1;
      creg_addr_t rs2;
      creg_addr_t rd;
      logic       use_rs1;
      logic       use_rs2;
      logic       wr_rd;
   } issue_req_t;

   // x0 is hardwired zero, so it never participates in hazards
   function automatic logic reg_live(creg_addr_t r);
      return r != '0;
   endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and issue-side handshakes plus register-file read indices.
interface decode_issue_ctrl_if;
   import decode_issue_ctrl_pkg::*;

   logic       in_valid;
   logic       in_ready;
   creg_addr_t in_rs1;
   creg_addr_t in_rs2;
   creg_addr_t in_rd;
   logic       in_use_rs1;
   logic       in_use_rs2;
   logic       in_wr_rd;
   logic       out_valid;
   logic       out_ready;
   creg_addr_t ra1;
   creg_addr_t ra2;

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_wr_rd,
      output out_ready,
      input  in_ready, out_valid, ra1, ra2
   );

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_wr_rd,
      input  out_ready,
      output in_ready, out_valid, ra1, ra2
   );

endinterface

// File: rtl/decode_issue_ctrl_issue_scoreboard.sv
// Pending-write bitmap: one set port (issue), one clear port (writeback),
// two source read ports and a WAW read port, plus a sticky bad-retire flag.
module issue_scoreboard
   import decode_issue_ctrl_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_i,
   input  creg_addr_t set_idx_i,
   input  logic       clr_i,
   input  creg_addr_t clr_idx_i,
   input  creg_addr_t rd1_idx_i,
   input  creg_addr_t rd2_idx_i,
   input  creg_addr_t waw_idx_i,
   output logic       rd1_pend_o,
   output logic       rd2_pend_o,
   output logic       waw_pend_o,
   output logic       err_o
);

   logic [NREG-1:0] pend_q, pend_d;
   logic            err_q;
   logic            clr_legal;

   assign rd1_pend_o = reg_live(rd1_idx_i) & pend_q[rd1_idx_i];
   assign rd2_pend_o = reg_live(rd2_idx_i) & pend_q[rd2_idx_i];
   assign waw_pend_o = reg_live(waw_idx_i) & pend_q[waw_idx_i];
   assign err_o      = err_q;

   // Retiring x0 or a register with no outstanding writer is a protocol error
   assign clr_legal = clr_i & reg_live(clr_idx_i) & pend_q[clr_idx_i];

   always_comb begin
      pend_d = pend_q;
      if (clr_legal) pend_d[clr_idx_i] = 1'b0;
      if (set_i & reg_live(set_idx_i)) pend_d[set_idx_i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         if (clr_i & ~clr_legal) err_q <= 1'b1;
      end
   end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: one-entry hold register, scoreboard hazard check,
// valid/ready issue with zero-bubble back-to-back flow and a stall counter.
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   decode_issue_ctrl_if.slave  fe,
   input  logic                wb_valid,
   input  creg_addr_t          wb_dst,
   input  logic                flush,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic                sb_err
);

   issue_req_t       hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             p_rs1, p_rs2, p_rd;
   logic             hazard, out_vld, in_rdy, issue;

   issue_scoreboard #(.NREG(NREG)) u_sb (
      .clk        (clk),
      .reset      (reset),
      .set_i      (issue & hold_q.wr_rd),
      .set_idx_i  (hold_q.rd),
      .clr_i      (wb_valid),
      .clr_idx_i  (wb_dst),
      .rd1_idx_i  (hold_q.rs1),
      .rd2_idx_i  (hold_q.rs2),
      .waw_idx_i  (hold_q.rd),
      .rd1_pend_o (p_rs1),
      .rd2_pend_o (p_rs2),
      .waw_pend_o (p_rd),
      .err_o      (sb_err)
   );

   assign hazard  = hold_vld_q & ((hold_q.use_rs1 & p_rs1) |
                                  (hold_q.use_rs2 & p_rs2) |
                                  (hold_q.wr_rd   & p_rd));
   assign out_vld = reset & hold_vld_q & ~hazard & ~flush;
   assign issue   = out_vld & fe.out_ready;
   // Refill in the same cycle the held instruction leaves
   assign in_rdy  = reset & (~hold_vld_q | issue);

   assign fe.out_valid = out_vld;
   assign fe.in_ready  = in_rdy;
   assign fe.ra1       = hold_q.rs1;
   assign fe.ra2       = hold_q.rs2;
   assign stall_cnt    = stall_cnt_q;

   always_comb begin
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         hold_vld_d = 1'b0;
      end else if (fe.in_valid & in_rdy) begin
         hold_d = '{rs1: fe.in_rs1, rs2: fe.in_rs2, rd: fe.in_rd,
                    use_rs1: fe.in_use_rs1, use_rs2: fe.in_use_rs2,
                    wr_rd: fe.in_wr_rd};
         hold_vld_d = 1'b1;
      end else if (issue) begin
         hold_vld_d = 1'b0;
      end
      if (hazard & ~flush) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed scenarios followed by randomized traffic, every cycle checked
// against a register-level model of the hold slot and pending set.
module tb_decode_issue_ctrl;
   logic        clk;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_dst;
   logic        flush;
   logic [31:0] stall_cnt;
   logic        sb_err;

   decode_issue_ctrl_if bus();

   decode_issue_ctrl #(.NREG(32), .CNT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .fe        (bus),
      .wb_valid  (wb_valid),
      .wb_dst    (wb_dst),
      .flush     (flush),
      .stall_cnt (stall_cnt),
      .sb_err    (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passes = 0;
   int total  = 0;

   bit          m_hv, m_known, m_err;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   bit          m_u1, m_u2, m_wr;
   bit          m_pend[32];
   logic [31:0] m_cnt;
   bit          obs_issue, obs_ov, obs_ir;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drv(bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                      bit u1, bit u2, bit wr);
      bus.in_valid = v; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
      bus.in_use_rs1 = u1; bus.in_use_rs2 = u2; bus.in_wr_rd = wr;
   endtask

   // One clock: check outputs mid-cycle, then advance the model at the edge.
   task automatic tick();
      bit blocked, ev, er, iss;
      #1;
      blocked = m_hv && ((m_u1 && m_rs1 != 0 && m_pend[m_rs1]) ||
                         (m_u2 && m_rs2 != 0 && m_pend[m_rs2]) ||
                         (m_wr && m_rd  != 0 && m_pend[m_rd]));
      ev = reset && m_hv && !blocked && !flush;
      er = reset && (!m_hv || (ev && bus.out_ready));
      check("out_valid", bus.out_valid, ev);
      check("in_ready", bus.in_ready, er);
      check("stall_cnt", stall_cnt, m_cnt);
      check("sb_err", sb_err, m_err);
      if (m_known) begin
         check("ra1", bus.ra1, m_rs1);
         check("ra2", bus.ra2, m_rs2);
      end
      obs_ov = bus.out_valid; obs_ir = bus.in_ready;
      obs_issue = bus.out_valid & bus.out_ready;
      @(posedge clk);
      if (!reset) begin
         m_hv = 0; m_known = 0; m_err = 0; m_cnt = 0;
         foreach (m_pend[i]) m_pend[i] = 0;
      end else begin
         iss = ev && bus.out_ready;
         if (m_hv && blocked && !flush) m_cnt = m_cnt + 1;
         if (wb_valid) begin
            if (wb_dst == 0 || !m_pend[wb_dst]) m_err = 1;
            else m_pend[wb_dst] = 0;
         end
         if (iss && m_wr && m_rd != 0) m_pend[m_rd] = 1;
         if (flush) m_hv = 0;
         else if (bus.in_valid && er) begin
            m_hv = 1; m_known = 1;
            m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2; m_rd = bus.in_rd;
            m_u1 = bus.in_use_rs1; m_u2 = bus.in_use_rs2; m_wr = bus.in_wr_rd;
         end else if (iss) m_hv = 0;
      end
      @(negedge clk);
   endtask

   task automatic wb(logic [4:0] r);
      wb_valid = 1; wb_dst = r; tick(); wb_valid = 0;
   endtask

   initial begin
      logic [31:0] base;
      int iss_cnt, rdy_cnt;
      logic [4:0] cand[$];
      reset = 0; wb_valid = 0; wb_dst = 0; flush = 0; bus.out_ready = 1;
      drv(0, 0, 0, 0, 0, 0, 0);
      m_cnt = 0;
      @(negedge clk);
      tick(); tick();
      reset = 1;

      // ADDI x5, x0: issues one cycle after acceptance, then retires
      drv(1, 0, 0, 5, 1, 0, 1); tick();
      bus.in_valid = 0; tick();
      check("addi_issue", obs_issue, 1);
      tick();
      wb(5);
      tick();
      check("addi_sb_err", sb_err, 0);
      drv(1, 5, 0, 11, 1, 0, 1); tick();
      bus.in_valid = 0; tick();
      check("x5_cleared", obs_issue, 1);
      wb(11);

      // LD x6 then ADD x7,x6,x1: three stall cycles until wb x6
      drv(1, 1, 0, 6, 1, 0, 1); tick();
      drv(1, 6, 1, 7, 1, 1, 1); tick();
      check("ld_issue", obs_issue, 1);
      base = m_cnt;
      bus.in_valid = 0; tick(); tick();
      wb(6);
      tick();
      check("add_issue", obs_issue, 1);
      check("ld_stall3", stall_cnt, base + 3);
      wb(7);

      // Eight independent writers back to back
      iss_cnt = 0; rdy_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         drv(1, 0, 0, 5'(i), 0, 0, 1); tick();
         rdy_cnt += int'(obs_ir);
         if (i > 1) iss_cnt += int'(obs_issue);
      end
      bus.in_valid = 0; tick();
      iss_cnt += int'(obs_issue);
      check("stream_issues", iss_cnt, 8);
      check("stream_in_ready", rdy_cnt, 8);
      for (int i = 1; i <= 8; i++) wb(5'(i));

      // Backpressure without hazard: holds, not counted as stall
      bus.out_ready = 0;
      drv(1, 0, 0, 10, 0, 0, 1); tick();
      bus.in_valid = 0; base = m_cnt;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_out_valid", obs_ov, 1);
         check("bp_in_ready", obs_ir, 0);
      end
      check("bp_no_stall", stall_cnt, base);
      bus.out_ready = 1; tick();
      check("bp_release", obs_issue, 1);
      wb(10);

      // Flush a blocked ADD x3,x2; x2 must stay pending
      drv(1, 0, 0, 2, 0, 0, 1); tick();
      drv(1, 2, 0, 3, 1, 0, 1); tick();
      bus.in_valid = 0; tick();
      check("add_blocked", obs_ov, 0);
      flush = 1; tick(); flush = 0;
      check("flush_no_issue", obs_issue, 0);
      tick();
      check("flush_empty", obs_ir, 1);
      drv(1, 2, 0, 12, 1, 0, 0); tick();
      bus.in_valid = 0; tick();
      check("x2_still_pending", obs_ov, 0);
      wb(2);
      tick();
      check("x2_released", obs_issue, 1);

      // Illegal retirements set a sticky error cleared only by reset
      wb(9);
      tick();
      check("sb_err_set", sb_err, 1);
      tick(); tick();
      check("sb_err_sticky", sb_err, 1);
      reset = 0; tick(); reset = 1; tick();
      check("sb_err_reset", sb_err, 0);
      wb(0);
      tick();
      check("sb_err_x0", sb_err, 1);
      reset = 0; tick(); reset = 1;

      // Randomized traffic, legal retirements only, occasional reset
      for (int n = 0; n < 800; n++) begin
         drv(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
         bus.out_ready = ($urandom % 4) != 0;
         flush = ($urandom % 20) == 0;
         reset = ($urandom % 150) != 0;
         cand.delete();
         for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(5'(r));
         wb_valid = 0;
         if (cand.size() != 0 && ($urandom % 3) == 0) begin
            wb_valid = 1;
            wb_dst = cand[$urandom_range(0, cand.size() - 1)];
         end
         tick();
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
